// File: rtl/mixcolumns_serial_if.sv
// Byte-stream bus between shiftrows, the serial MixColumns stage and its consumer.
interface mixcolumns_serial_if;
    logic [7:0] inBits;
    logic       inValid;
    logic       bypass;
    logic [7:0] outBits;
    logic       ready;

    modport master (output inBits, inValid, bypass, input outBits, ready);
    modport slave  (input inBits, inValid, bypass, output outBits, ready);
endinterface

// File: rtl/mixcolumns_serial.sv
// Byte-serial AES MixColumns: gathers one column, mixes it on the row3 byte and
// emits the four results on consecutive cycles with no bubble between columns.
//
// state | meaning
// IDLE  | no column pending, ready low, outBits holds last byte
// EMIT  | presenting bank[outCnt] with ready high
module mixcolumns_serial (
    input  logic                 clk,
    input  logic                 reset,
    mixcolumns_serial_if.slave   bus
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t     state_q, state_d;
    logic [1:0] in_cnt_q, in_cnt_d;
    logic [1:0] out_cnt_q, out_cnt_d;
    logic [7:0] hold_q [3];
    logic [7:0] hold_d [3];
    logic [7:0] bank_q [4];
    logic [7:0] bank_d [4];
    logic       col_bypass_q, col_bypass_d;
    logic [7:0] out_bits_q, out_bits_d;
    logic [7:0] mix [4];
    logic [7:0] col [4];
    logic [1:0] out_nxt;
    logic       load;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [7:0] mul3(input logic [7:0] a);
        return xtime(a) ^ a;
    endfunction

    // Row3 never lands in the holding register; it is mixed straight from inBits.
    always_comb begin
        in_cnt_d     = in_cnt_q;
        hold_d       = hold_q;
        col_bypass_d = col_bypass_q;
        load         = 1'b0;
        if (bus.inValid) begin
            in_cnt_d = in_cnt_q + 2'd1;
            case (in_cnt_q)
                2'd0: begin
                    hold_d[0]    = bus.inBits;
                    col_bypass_d = bus.bypass;
                end
                2'd1: hold_d[1] = bus.inBits;
                2'd2: hold_d[2] = bus.inBits;
                default: load = 1'b1;
            endcase
        end
    end

    always_comb begin
        col[0] = hold_q[0];
        col[1] = hold_q[1];
        col[2] = hold_q[2];
        col[3] = bus.inBits;
        if (col_bypass_q) begin
            mix = col;
        end else begin
            mix[0] = xtime(col[0]) ^ mul3(col[1]) ^ col[2] ^ col[3];
            mix[1] = col[0] ^ xtime(col[1]) ^ mul3(col[2]) ^ col[3];
            mix[2] = col[0] ^ col[1] ^ xtime(col[2]) ^ mul3(col[3]);
            mix[3] = mul3(col[0]) ^ col[1] ^ col[2] ^ xtime(col[3]);
        end
    end

    always_comb begin
        state_d    = state_q;
        out_cnt_d  = out_cnt_q;
        out_bits_d = out_bits_q;
        bank_d     = bank_q;
        out_nxt    = out_cnt_q + 2'd1;
        if (load) begin
            bank_d     = mix;
            out_bits_d = mix[0];
            out_cnt_d  = 2'd0;
            state_d    = EMIT;
        end else if (state_q == EMIT) begin
            if (out_cnt_q == 2'd3) begin
                state_d = IDLE;
            end else begin
                out_cnt_d  = out_nxt;
                out_bits_d = bank_q[out_nxt];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            in_cnt_q     <= 2'd0;
            out_cnt_q    <= 2'd0;
            hold_q       <= '{default: 8'h00};
            bank_q       <= '{default: 8'h00};
            col_bypass_q <= 1'b0;
            out_bits_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            hold_q       <= hold_d;
            bank_q       <= bank_d;
            col_bypass_q <= col_bypass_d;
            out_bits_q   <= out_bits_d;
        end
    end

    assign bus.outBits = out_bits_q;
    assign bus.ready   = (state_q == EMIT);

endmodule

// File: tb/tb_mixcolumns_serial.sv
// Directed-vector bench for mixcolumns_serial with hand-computed AES columns.
module tb_mixcolumns_serial;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;

    logic [7:0] got_q [$];
    int         stamp_q [$];
    logic [7:0] exp_q [$];

    mixcolumns_serial_if bus ();

    mixcolumns_serial dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.ready === 1'b1) begin
            got_q.push_back(bus.outBits);
            stamp_q.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns the cycle stamp at which the first result of a column is expected.
    task automatic send(input logic [7:0] b, input logic byp, output int stamp);
        @(negedge clk);
        bus.inBits  = b;
        bus.inValid = 1'b1;
        bus.bypass  = byp;
        stamp       = cyc + 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.inValid = 1'b0;
            bus.bypass  = 1'b0;
            bus.inBits  = 8'h00;
        end
    endtask

    task automatic clear_capture();
        got_q.delete();
        stamp_q.delete();
    endtask

    task automatic compare_out(input string tag, input int first_stamp);
        logic [31:0] obs;
        check({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            obs = (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hFFFF_FFFF;
            check($sformatf("%s byte%0d", tag, i), obs, {24'h0, exp_q[i]});
        end
        if (stamp_q.size() > 0) begin
            check({tag, " latency"}, stamp_q[0], first_stamp);
            check({tag, " contiguous"}, stamp_q[stamp_q.size()-1] - stamp_q[0],
                  stamp_q.size() - 1);
        end
    endtask

    logic [7:0] vec [$];
    int         st;
    int         first;

    initial begin
        cyc         = 0;
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.inBits  = 8'h00;
        bus.inValid = 1'b0;
        bus.bypass  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset ready", bus.ready, 1'b0);
        check("reset outBits", bus.outBits, 8'h00);
        reset = 1'b0;
        idle(2);

        // single column
        clear_capture();
        exp_q = '{8'h04, 8'h66, 8'h81, 8'he5};
        vec   = '{8'hd4, 8'hbf, 8'h5d, 8'h30};
        foreach (vec[i]) send(vec[i], 1'b0, st);
        first = st;
        idle(8);
        compare_out("col1", first);
        check("idle hold outBits", bus.outBits, 8'he5);
        check("idle ready", bus.ready, 1'b0);

        // four columns streamed back to back
        clear_capture();
        exp_q = '{8'h04, 8'h66, 8'h81, 8'he5, 8'he0, 8'hcb, 8'h19, 8'h9a,
                  8'h48, 8'hf8, 8'hd3, 8'h7a, 8'h28, 8'h06, 8'h26, 8'h4c};
        vec   = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                  8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
        first = 0;
        foreach (vec[i]) begin
            send(vec[i], 1'b0, st);
            if (i == 3) first = st;
        end
        idle(8);
        compare_out("stream16", first);

        // gap between row1 and row2
        clear_capture();
        exp_q = '{8'h9f, 8'hdc, 8'h58, 8'h9d};
        send(8'hf2, 1'b0, st);
        send(8'h0a, 1'b0, st);
        idle(2);
        send(8'h22, 1'b0, st);
        send(8'h5c, 1'b0, st);
        first = st;
        idle(8);
        compare_out("gap", first);

        // bypass column, then a mixed column with bypass only on non-row0 bytes
        clear_capture();
        exp_q = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'h8e, 8'h4d, 8'ha1, 8'hbc};
        send(8'hd4, 1'b1, st);
        first = 0;
        send(8'hbf, 1'b0, st);
        send(8'h5d, 1'b0, st);
        send(8'h30, 1'b0, st);
        first = st;
        send(8'hdb, 1'b0, st);
        send(8'h13, 1'b1, st);
        send(8'h53, 1'b1, st);
        send(8'h45, 1'b1, st);
        idle(8);
        compare_out("bypass", first);

        // fixed-point columns
        clear_capture();
        exp_q = '{8'h01, 8'h01, 8'h01, 8'h01, 8'hc6, 8'hc6, 8'hc6, 8'hc6};
        vec   = '{8'h01, 8'h01, 8'h01, 8'h01, 8'hc6, 8'hc6, 8'hc6, 8'hc6};
        foreach (vec[i]) begin
            send(vec[i], 1'b0, st);
            if (i == 3) first = st;
        end
        idle(8);
        compare_out("fixed", first);

        // reset mid-column discards the partial column
        clear_capture();
        send(8'haa, 1'b0, st);
        send(8'h55, 1'b0, st);
        idle(1);
        #1 reset = 1'b1;
        #1;
        check("midcol reset ready", bus.ready, 1'b0);
        check("midcol reset outBits", bus.outBits, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        exp_q = '{8'h04, 8'h66, 8'h81, 8'he5};
        vec   = '{8'hd4, 8'hbf, 8'h5d, 8'h30};
        foreach (vec[i]) send(vec[i], 1'b0, st);
        first = st;
        idle(8);
        compare_out("midcol", first);

        // reset during emission aborts the rest of the column
        clear_capture();
        exp_q = '{8'h04, 8'h66};
        foreach (vec[i]) send(vec[i], 1'b0, st);
        first = st;
        idle(2);
        #1 reset = 1'b1;
        #1;
        check("emit reset ready", bus.ready, 1'b0);
        check("emit reset outBits", bus.outBits, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        idle(8);
        compare_out("abort", first);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
